// File: rtl/intc_dev.sv
// Interrupt controller: synchronizes raw device lines, latches edge/level events,
// masks and priority-encodes them, and exposes its registers over the peripheral bus.
module intc_dev #(
  parameter int N_SRC       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  input  logic [1:0]       sel_i,
  input  logic             rd_i,
  input  logic             we_i,
  output logic             ack_o,
  output logic             irq_o,
  output logic [4:0]       irq_id_o
);

  // Bus handshake: rd_i/we_i are levels held by the master until ack_o;
  // ack_o pulses for one cycle, and the FSM then waits for both requests to drop
  // so a request held across ack never starts a second access.
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} bus_state_e;
  bus_state_e state, state_next;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync, prev_q;
  logic [N_SRC-1:0] pending_q, pending_next, mask_q, mode_q, active, clr;
  logic [4:0]       id_next;
  logic [31:0]      rdata;
  logic [2:0]       off;
  logic             access, wr;
  logic             unused_bits;

  function automatic logic [31:0] pad(input logic [N_SRC-1:0] v);
    pad = '0;
    pad[N_SRC-1:0] = v;
  endfunction

  assign unused_bits = ^{sel_i, addr_i[31:5], addr_i[1:0], data_i};

  assign sync   = sync_q[SYNC_STAGES-1];
  assign off    = addr_i[4:2];
  assign access = (state == S_IDLE) && (rd_i || we_i);
  assign wr     = access && we_i;
  assign clr    = (wr && off == 3'd2) ? data_i[N_SRC-1:0] : '0;
  assign active = pending_q & mask_q;
  assign ack_o  = (state == S_ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= src_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync;
    end
  end

  // Edge sources: a detected edge beats a simultaneous CLEAR.
  always_comb begin
    pending_next = pending_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode_q[i]) pending_next[i] = (pending_q[i] & ~clr[i]) | (sync[i] & ~prev_q[i]);
      else           pending_next[i] = sync[i];
    end
  end

  always_comb begin
    id_next = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) id_next = i[4:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      3'd0:    rdata = pad(pending_q);
      3'd1:    rdata = pad(mask_q);
      3'd3:    rdata = pad(mode_q);
      3'd4:    rdata = {|active, 26'b0, id_next};
      3'd5:    rdata = pad(sync);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      irq_o     <= 1'b0;
      irq_id_o  <= '0;
    end else begin
      pending_q <= pending_next;
      if (wr && off == 3'd1) mask_q <= data_i[N_SRC-1:0];
      if (wr && off == 3'd3) mode_q <= data_i[N_SRC-1:0];
      irq_o    <= |active;
      irq_id_o <= id_next;
    end
  end

  // Read data is captured before the write lands, so a combined rd/we returns the old value.
  always_ff @(posedge clk) begin
    if (rst)                  data_o <= '0;
    else if (access && rd_i)  data_o <= rdata;
    else                      data_o <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (rd_i || we_i) state_next = S_ACK;
      S_ACK:   state_next = S_WAIT;
      S_WAIT:  if (!rd_i && !we_i) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

endmodule
